// File: rtl/acq_capture_ctrl.sv
// Trigger-qualified multi-channel ADC capture into a 32-bit byte-addressed BRAM.
// state | meaning: IDLE waiting for arm | ARMED waiting for trigger | CAPTURE writing window | DONE window complete
module acq_capture_ctrl #(
  parameter int DATA_W   = 14,
  parameter int CH       = 2,
  parameter int LEN_W    = 10,
  parameter int SIGN_EXT = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_arm,
  input  logic                   i_abort,
  input  logic [1:0]             i2_trig_mode,
  input  logic                   i_sw_trig,
  input  logic                   i_ext_trig,
  input  logic [LEN_W-1:0]       i_len,
  input  logic                   i_sample_valid,
  input  logic [CH*DATA_W-1:0]   i_data,
  output logic [3:0]             o4_bram_we,
  output logic [31:0]            o32_bram_addr,
  output logic [31:0]            o32_bram_data,
  output logic                   o_bram_en,
  output logic                   o_bram_rst,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_irq,
  output logic                   o_overrun,
  output logic [LEN_W+3:0]       o_words
);

  localparam int WW = LEN_W + 4;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_ext_d;
  logic [1:0]            r_mode;
  logic [WW-1:0]         r_target;
  logic [WW-1:0]         r_words;
  logic [3:0]            r_rem;
  logic [CH*DATA_W-1:0]  r_shift;
  logic [3:0]            r_we;
  logic [31:0]           r_addr;
  logic [31:0]           r_data;
  logic                  r_irq;
  logic                  r_ovr;

  logic                  w_trig_cond;
  logic                  w_trig;
  logic                  w_ser_busy;
  logic                  w_accept;
  logic                  w_ser_wr;
  logic                  w_wr;
  logic                  w_last;
  logic                  w_arm_ok;
  logic [DATA_W-1:0]     w_sample;
  logic [WW-1:0]         w_len_eff;
  logic [WW-1:0]         w_target_in;

  function automatic logic [31:0] f_ext(input logic [DATA_W-1:0] s);
    if (SIGN_EXT != 0) return 32'($signed(s));
    else               return 32'(s);
  endfunction

  always_comb begin
    w_trig_cond = 1'b1;
    case (r_mode)
      2'd1:    w_trig_cond = i_sw_trig;
      2'd2:    w_trig_cond = i_ext_trig & ~r_ext_d;
      default: w_trig_cond = 1'b1;
    endcase
  end

  assign w_trig      = (r_state == S_ARMED) & w_trig_cond;
  assign w_ser_busy  = (r_rem != 4'd0);
  assign w_accept    = i_sample_valid &
                       (((r_state == S_CAPTURE) & ~w_ser_busy) | w_trig);
  assign w_ser_wr    = (r_state == S_CAPTURE) & w_ser_busy;
  assign w_wr        = w_accept | w_ser_wr;
  assign w_last      = w_wr & (r_words == (r_target - WW'(1)));
  assign w_arm_ok    = i_arm & ~i_abort & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_sample    = w_accept ? i_data[DATA_W-1:0] : r_shift[DATA_W-1:0];
  // A zero length selects the full 2^LEN_W window.
  assign w_len_eff   = (i_len == '0) ? (WW'(1) << LEN_W) : WW'(i_len);
  assign w_target_in = w_len_eff * WW'(CH);

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (i_arm) w_state_nxt = S_ARMED;
        S_ARMED: begin
          if (w_last)      w_state_nxt = S_DONE;
          else if (w_trig) w_state_nxt = S_CAPTURE;
        end
        S_CAPTURE: if (w_last) w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_ARMED, S_CAPTURE: o_busy = 1'b1;
      S_DONE:             o_done = 1'b1;
      default: ;
    endcase
  end

  // Channel 0 is written straight from i_data; the rest drain from r_shift.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ext_d  <= 1'b0;
      r_mode   <= 2'd0;
      r_target <= '0;
      r_words  <= '0;
      r_rem    <= 4'd0;
      r_shift  <= '0;
      r_we     <= 4'd0;
      r_addr   <= 32'd0;
      r_data   <= 32'd0;
      r_irq    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_ext_d <= i_ext_trig;
      r_we    <= 4'd0;
      r_irq   <= 1'b0;
      if (i_abort) begin
        r_rem <= 4'd0;
        r_ovr <= 1'b0;
      end else begin
        if (w_arm_ok) begin
          r_mode   <= i2_trig_mode;
          r_target <= w_target_in;
          r_words  <= '0;
          r_ovr    <= 1'b0;
        end
        if (w_wr) begin
          r_we    <= 4'b1111;
          r_addr  <= 32'({r_words, 2'b00});
          r_data  <= f_ext(w_sample);
          r_words <= r_words + WW'(1);
          r_irq   <= w_last;
        end
        if (w_accept) begin
          r_shift <= i_data >> DATA_W;
          r_rem   <= 4'(CH - 1);
        end else if (w_ser_wr) begin
          r_shift <= r_shift >> DATA_W;
          r_rem   <= r_rem - 4'd1;
        end
        if (i_sample_valid & w_ser_wr) r_ovr <= 1'b1;
      end
    end
  end

  assign o4_bram_we    = r_we;
  assign o32_bram_addr = r_addr;
  assign o32_bram_data = r_data;
  assign o_bram_en     = 1'b1;
  assign o_bram_rst    = ~rstn;
  assign o_irq         = r_irq;
  assign o_overrun     = r_ovr;
  assign o_words       = r_words;

endmodule

// File: tb/tb_acq_capture_ctrl.sv
// Bench for acq_capture_ctrl: directed scenarios plus random traffic against a
// queue-based transaction model; a second CH=1 sign-extending instance is checked directly.
module tb_acq_capture_ctrl;
  localparam int DW = 14;
  localparam int CH = 2;
  localparam int LW = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic            arm = 0, abort = 0, sw = 0, ext = 0, valid = 0;
  logic [1:0]      mode = 0;
  logic [LW-1:0]   len = 0;
  logic [CH*DW-1:0] data = 0;
  logic [3:0]      we;
  logic [31:0]     addr, wdata;
  logic            en, brst, busy, done, irq, ovr;
  logic [LW+3:0]   words;

  logic            b_arm = 0, b_abort = 0, b_sw = 0, b_ext = 0, b_valid = 0;
  logic [1:0]      b_mode = 0;
  logic [2:0]      b_len = 0;
  logic [13:0]     b_data = 0;
  logic [3:0]      b_we;
  logic [31:0]     b_addr, b_wdata;
  logic            b_en, b_brst, b_busy, b_done, b_irq, b_ovr;
  logic [6:0]      b_words;

  acq_capture_ctrl #(.DATA_W(DW), .CH(CH), .LEN_W(LW), .SIGN_EXT(0)) u_dut (
    .clk(clk), .rstn(rstn), .i_arm(arm), .i_abort(abort), .i2_trig_mode(mode),
    .i_sw_trig(sw), .i_ext_trig(ext), .i_len(len), .i_sample_valid(valid),
    .i_data(data), .o4_bram_we(we), .o32_bram_addr(addr), .o32_bram_data(wdata),
    .o_bram_en(en), .o_bram_rst(brst), .o_busy(busy), .o_done(done), .o_irq(irq),
    .o_overrun(ovr), .o_words(words));

  acq_capture_ctrl #(.DATA_W(14), .CH(1), .LEN_W(3), .SIGN_EXT(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .i_arm(b_arm), .i_abort(b_abort), .i2_trig_mode(b_mode),
    .i_sw_trig(b_sw), .i_ext_trig(b_ext), .i_len(b_len), .i_sample_valid(b_valid),
    .i_data(b_data), .o4_bram_we(b_we), .o32_bram_addr(b_addr), .o32_bram_data(b_wdata),
    .o_bram_en(b_en), .o_bram_rst(b_brst), .o_busy(b_busy), .o_done(b_done), .o_irq(b_irq),
    .o_overrun(b_ovr), .o_words(b_words));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 armed, 2 capture, 3 done; pending writes in a queue.
  int          m_phase, m_mode, m_target, m_words;
  bit          m_ovr, m_prev, e_we, e_irq;
  logic [31:0] e_addr, e_data;
  logic [31:0] q_wr[$];

  task automatic model_step();
    bit trig;
    if (!rstn) begin
      m_phase = 0; m_mode = 0; m_target = 0; m_words = 0; m_ovr = 0; m_prev = 0;
      e_we = 0; e_irq = 0; e_addr = 0; e_data = 0;
      q_wr.delete();
    end else begin
      e_we = 0;
      e_irq = 0;
      if (abort) begin
        m_phase = 0;
        q_wr.delete();
        m_ovr = 0;
      end else if (m_phase == 0 || m_phase == 3) begin
        if (arm) begin
          m_phase  = 1;
          m_mode   = int'(mode);
          m_target = ((len == 0) ? (1 << LW) : int'(len)) * CH;
          m_words  = 0;
          m_ovr    = 0;
        end
      end else begin
        case (m_mode)
          1:       trig = sw;
          2:       trig = ext && !m_prev;
          default: trig = 1;
        endcase
        trig = trig && (m_phase == 1);
        if (m_phase == 2 && q_wr.size() != 0 && valid) m_ovr = 1;
        if (valid && (trig || (m_phase == 2 && q_wr.size() == 0)))
          for (int k = 0; k < CH; k++) q_wr.push_back({18'd0, data[k*DW +: DW]});
        if (trig) m_phase = 2;
        if (q_wr.size() != 0) begin
          e_we   = 1;
          e_addr = 32'(m_words * 4);
          e_data = q_wr.pop_front();
          m_words++;
          if (m_words == m_target) begin
            m_phase = 3;
            e_irq   = 1;
          end
        end
      end
      m_prev = ext;
    end
  endtask

  task automatic compare_all();
    chk("we", 32'(we), e_we ? 32'hF : 32'h0);
    chk("addr", addr, e_addr);
    chk("data", wdata, e_data);
    chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
    chk("done", 32'(done), 32'(m_phase == 3));
    chk("irq", 32'(irq), 32'(e_irq));
    chk("overrun", 32'(ovr), 32'(m_ovr));
    chk("words", 32'(words), 32'(m_words));
    chk("bram_en", 32'(en), 32'h1);
    chk("bram_rst", 32'(brst), 32'(!rstn));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic quiet();
    arm = 0; abort = 0; sw = 0; valid = 0;
  endtask

  int dens;

  initial begin
    @(negedge clk);
    rstn = 0;
    repeat (3) cycle();
    chk("rst_we", 32'(we), 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_data", wdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_words", 32'(words), 32'h0);
    rstn = 1;
    cycle();

    // Immediate mode, len 4, valid every 3 cycles
    arm = 1; mode = 0; len = 4; cycle(); quiet();
    for (int i = 0; i < 16; i++) begin
      valid = (i % 3 == 0);
      data  = {14'(14'h0123 + i), 14'(14'h2000 + i)};
      cycle();
    end
    quiet();
    chk("tp1_done", 32'(done), 32'h1);
    chk("tp1_words", 32'(words), 32'd8);
    chk("tp1_last_addr", addr, 32'd28);

    // External edge mode with the level already high at arm
    ext = 1; arm = 1; mode = 2; len = 2; cycle(); quiet();
    valid = 1;
    repeat (4) begin data = CH*DW'($urandom); cycle(); end
    chk("tp2_no_wr", 32'(words), 32'd0);
    ext = 0;
    repeat (3) begin data = CH*DW'($urandom); cycle(); end
    ext = 1;
    repeat (8) begin data = CH*DW'($urandom); cycle(); end
    quiet();
    chk("tp2_words", 32'(words), 32'd4);
    chk("tp2_done", 32'(done), 32'h1);

    // Back-to-back valids drop every second event
    arm = 1; mode = 0; len = 3; cycle(); quiet();
    valid = 1;
    repeat (12) begin data = CH*DW'($urandom); cycle(); end
    quiet();
    chk("tp3_words", 32'(words), 32'd6);
    chk("tp3_overrun", 32'(ovr), 32'h1);

    // Abort while channel 1 is pending, then re-arm
    arm = 1; mode = 0; len = 4; cycle(); quiet();
    valid = 1; data = CH*DW'($urandom); cycle();
    valid = 0; abort = 1; cycle(); abort = 0;
    chk("abort_we", 32'(we), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    arm = 1; cycle(); quiet();
    valid = 1; data = CH*DW'($urandom); cycle(); valid = 0;
    chk("rearm_we", 32'(we), 32'hF);
    chk("rearm_addr", addr, 32'h0);
    repeat (3) cycle();

    // CH=1, LEN_W=3, len 0, sign extension, valid held high
    b_arm = 1; cycle(); b_arm = 0;
    b_valid = 1;
    for (int k = 0; k < 8; k++) begin
      b_data = 14'(14'h2000 + k);
      cycle();
      chk("b_we", 32'(b_we), 32'hF);
      chk("b_addr", b_addr, 32'(4 * k));
      chk("b_data", b_wdata, 32'hFFFFE000 + 32'(k));
      chk("b_irq", 32'(b_irq), 32'(k == 7));
      chk("b_done", 32'(b_done), 32'(k == 7));
    end
    b_data = 14'h1FFF;
    cycle();
    b_valid = 0;
    chk("b_post_we", 32'(b_we), 32'h0);
    chk("b_post_done", 32'(b_done), 32'h1);
    chk("b_post_words", 32'(b_words), 32'd8);
    chk("b_ovr", 32'(b_ovr), 32'h0);
    chk("b_busy", 32'(b_busy), 32'h0);
    chk("b_en", 32'(b_en), 32'h1);
    chk("b_rst", 32'(b_brst), 32'h0);

    // Random traffic
    dens = 3;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) dens = int'($urandom_range(1, 4));
      arm   = ($urandom_range(0, 11) == 0);
      abort = ($urandom_range(0, 199) == 0);
      sw    = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) ext = ~ext;
      mode  = 2'($urandom_range(0, 3));
      len   = LW'($urandom_range(1, 6));
      valid = ($urandom_range(0, dens - 1) == 0);
      data  = CH*DW'($urandom);
      cycle();
    end
    quiet();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
